cpsd_rhythm_classifier: RTL and testbench

//  Back-end decision unit for the CPSD arrhythmia detector.

---
 rtl/cpsd_rhythm_classifier.sv | 223 ++++++++++++++++++++++
 tb/tb_cpsd_rhythm_classifier.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpsd_rhythm_classifier.sv
// Back-end decision unit of the CPSD arrhythmia detector: owns the analysis
// window timer, classifies each returned CPSD value against programmable
// thresholds and majority-votes recent windows into normal/AF/VF.
module cpsd_rhythm_classifier #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned PERIOD     = 1600,
   parameter int unsigned NB_WINDOWS = 3,
   parameter int unsigned TIMEOUT    = 64,
   parameter int unsigned VF_FAST    = 1
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  en,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  cpsd_valid,
   input  logic [DATA_WIDTH-1:0] cpsd,
   input  logic                  cfg_we,
   input  logic [DATA_WIDTH-1:0] cfg_thr1,
   input  logic [DATA_WIDTH-1:0] cfg_thr2,
   output logic                  window_end,
   output logic                  normal,
   output logic                  AF,
   output logic                  VF,
   output logic                  result_valid,
   output logic                  busy,
   output logic                  timeout_err,
   output logic                  cfg_err
);

   // One counter serves both the window timer (RUN) and the reply timeout (WAIT).
   localparam int unsigned CNT_MAX = (PERIOD > TIMEOUT) ? PERIOD : TIMEOUT;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int unsigned FILL_W  = $clog2(NB_WINDOWS + 1);
   localparam int unsigned HALF    = NB_WINDOWS / 2;

   localparam logic [CNT_W-1:0]      PERIOD_LAST  = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0]      TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [FILL_W-1:0]     FILL_FULL    = FILL_W'(NB_WINDOWS);
   localparam logic [FILL_W-1:0]     VOTE_HALF    = FILL_W'(HALF);
   localparam logic [DATA_WIDTH-1:0] THR1_RESET   = DATA_WIDTH'(5);
   localparam logic [DATA_WIDTH-1:0] THR2_RESET   = DATA_WIDTH'(10);

   localparam logic [1:0] CLS_N  = 2'd0;
   localparam logic [1:0] CLS_AF = 2'd1;
   localparam logic [1:0] CLS_VF = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_WAIT   = 2'd2,
      S_DECIDE = 2'd3
   } state_t;

   state_t                state;
   logic [CNT_W-1:0]      cnt;
   logic [DATA_WIDTH-1:0] cpsd_q;
   logic [DATA_WIDTH-1:0] thr1;
   logic [DATA_WIDTH-1:0] thr2;
   logic [1:0]            hist [NB_WINDOWS];
   logic [FILL_W-1:0]     fill;

   logic [1:0]            cls_c;
   logic [1:0]            hist_nxt [NB_WINDOWS];
   logic [FILL_W-1:0]     fill_nxt;
   logic [FILL_W-1:0]     n_cnt;
   logic [FILL_W-1:0]     af_cnt;
   logic [FILL_W-1:0]     vf_cnt;
   logic                  full_c;

   // Classify the latched CPSD value and tally the history as it will look after the push.
   always_comb begin
      cls_c = CLS_N;
      if (cpsd_q >= thr2) begin
         cls_c = CLS_VF;
      end else if (cpsd_q >= thr1) begin
         cls_c = CLS_AF;
      end

      hist_nxt[0] = cls_c;
      for (int i = 1; i < int'(NB_WINDOWS); i++) begin
         hist_nxt[i] = hist[i-1];
      end

      fill_nxt = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
      full_c   = (fill_nxt == FILL_FULL);

      n_cnt  = '0;
      af_cnt = '0;
      vf_cnt = '0;
      for (int i = 0; i < int'(NB_WINDOWS); i++) begin
         if (hist_nxt[i] == CLS_N) begin
            n_cnt = n_cnt + FILL_W'(1);
         end else if (hist_nxt[i] == CLS_AF) begin
            af_cnt = af_cnt + FILL_W'(1);
         end else begin
            vf_cnt = vf_cnt + FILL_W'(1);
         end
      end
   end

   // Control FSM, window/timeout counter, history, thresholds and registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= S_IDLE;
         cnt          <= '0;
         cpsd_q       <= '0;
         thr1         <= THR1_RESET;
         thr2         <= THR2_RESET;
         fill         <= '0;
         for (int i = 0; i < int'(NB_WINDOWS); i++) begin
            hist[i] <= CLS_N;
         end
         window_end   <= 1'b0;
         normal       <= 1'b0;
         AF           <= 1'b0;
         VF           <= 1'b0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
         timeout_err  <= 1'b0;
         cfg_err      <= 1'b0;
      end else if (!en) begin
         // Frozen: only the single-cycle pulses drop.
         window_end   <= 1'b0;
         result_valid <= 1'b0;
         cfg_err      <= 1'b0;
      end else begin
         window_end   <= 1'b0;
         result_valid <= 1'b0;
         cfg_err      <= 1'b0;

         if (stop) begin
            // Abort keeps class outputs and history until the next start.
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  // A same-cycle write lands before the start takes effect.
                  if (cfg_we) begin
                     if (cfg_thr1 <= cfg_thr2) begin
                        thr1 <= cfg_thr1;
                        thr2 <= cfg_thr2;
                     end else begin
                        cfg_err <= 1'b1;
                     end
                  end
                  if (start) begin
                     state       <= S_RUN;
                     cnt         <= '0;
                     fill        <= '0;
                     for (int i = 0; i < int'(NB_WINDOWS); i++) begin
                        hist[i] <= CLS_N;
                     end
                     timeout_err <= 1'b0;
                     busy        <= 1'b1;
                  end
               end

               S_RUN: begin
                  if (cnt == PERIOD_LAST) begin
                     window_end <= 1'b1;
                     state      <= S_WAIT;
                     cnt        <= '0;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end

               S_WAIT: begin
                  // Data arriving on the last allowed cycle still wins over the timeout.
                  if (cpsd_valid) begin
                     cpsd_q <= cpsd;
                     state  <= S_DECIDE;
                     cnt    <= '0;
                  end else if (cnt == TIMEOUT_LAST) begin
                     timeout_err <= 1'b1;
                     state       <= S_RUN;
                     cnt         <= '0;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end

               S_DECIDE: begin
                  hist         <= hist_nxt;
                  fill         <= fill_nxt;
                  result_valid <= 1'b1;
                  if ((VF_FAST != 0) && (cls_c == CLS_VF)) begin
                     normal <= 1'b0;
                     AF     <= 1'b0;
                     VF     <= 1'b1;
                  end else if (full_c) begin
                     if (n_cnt > VOTE_HALF) begin
                        normal <= 1'b1;
                        AF     <= 1'b0;
                        VF     <= 1'b0;
                     end else if (af_cnt > VOTE_HALF) begin
                        normal <= 1'b0;
                        AF     <= 1'b1;
                        VF     <= 1'b0;
                     end else if (vf_cnt > VOTE_HALF) begin
                        normal <= 1'b0;
                        AF     <= 1'b0;
                        VF     <= 1'b1;
                     end
                  end
                  state <= S_RUN;
                  cnt   <= '0;
               end

               default: begin
                  state <= S_IDLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cpsd_rhythm_classifier.sv
// Self-checking bench for cpsd_rhythm_classifier: directed scenarios plus
// randomized sessions against a queue-based reference model.
module tb_cpsd_rhythm_classifier;

   localparam int unsigned DW      = 16;
   localparam int unsigned PERIOD  = 8;
   localparam int unsigned NB      = 3;
   localparam int unsigned TIMEOUT = 4;
   localparam int unsigned VF_FAST = 1;

   logic          clk = 1'b0;
   logic          rstn;
   logic          en;
   logic          start;
   logic          stop;
   logic          cpsd_valid;
   logic [DW-1:0] cpsd;
   logic          cfg_we;
   logic [DW-1:0] cfg_thr1;
   logic [DW-1:0] cfg_thr2;
   logic          window_end;
   logic          normal;
   logic          af;
   logic          vf;
   logic          result_valid;
   logic          busy;
   logic          timeout_err;
   logic          cfg_err;

   always #5 clk = ~clk;

   cpsd_rhythm_classifier #(
      .DATA_WIDTH (DW),
      .PERIOD     (PERIOD),
      .NB_WINDOWS (NB),
      .TIMEOUT    (TIMEOUT),
      .VF_FAST    (VF_FAST)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .en           (en),
      .start        (start),
      .stop         (stop),
      .cpsd_valid   (cpsd_valid),
      .cpsd         (cpsd),
      .cfg_we       (cfg_we),
      .cfg_thr1     (cfg_thr1),
      .cfg_thr2     (cfg_thr2),
      .window_end   (window_end),
      .normal       (normal),
      .AF           (af),
      .VF           (vf),
      .result_valid (result_valid),
      .busy         (busy),
      .timeout_err  (timeout_err),
      .cfg_err      (cfg_err)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int run_edges = 0;

   // Reference model state.
   logic [DW-1:0] m_thr1;
   logic [DW-1:0] m_thr2;
   logic [2:0]    m_cls;   // {normal, AF, VF}
   logic          m_terr;
   int            m_hist[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (en) run_edges++;
      #1;
   endtask

   function automatic void model_reset();
      m_thr1 = 16'd5;
      m_thr2 = 16'd10;
      m_cls  = 3'b000;
      m_terr = 1'b0;
      m_hist.delete();
   endfunction

   function automatic int classify(input logic [DW-1:0] v);
      if (v < m_thr1) return 0;
      if (v < m_thr2) return 1;
      return 2;
   endfunction

   function automatic void model_decide(input logic [DW-1:0] v);
      int c;
      int cnt[3];
      c = classify(v);
      m_hist.push_front(c);
      if (m_hist.size() > NB) void'(m_hist.pop_back());
      if (VF_FAST != 0 && c == 2) begin
         m_cls = 3'b001;
      end else if (m_hist.size() == NB) begin
         cnt = '{0, 0, 0};
         foreach (m_hist[i]) cnt[m_hist[i]]++;
         if (cnt[0] > NB / 2)      m_cls = 3'b100;
         else if (cnt[1] > NB / 2) m_cls = 3'b010;
         else if (cnt[2] > NB / 2) m_cls = 3'b001;
      end
   endfunction

   function automatic bit model_cfg(input logic [DW-1:0] t1, input logic [DW-1:0] t2);
      if (t1 <= t2) begin
         m_thr1 = t1;
         m_thr2 = t2;
         return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic void model_start();
      m_hist.delete();
      m_terr = 1'b0;
   endfunction

   task automatic start_session();
      start = 1'b1;
      tick();
      start = 1'b0;
      model_start();
      run_edges = 0;
      chk("start_busy", busy, 1);
      chk("start_terr", timeout_err, m_terr);
   endtask

   task automatic wait_window_end();
      int guard = 0;
      while (window_end !== 1'b1 && guard < 60) begin
         tick();
         guard++;
      end
      chk("win_end_seen", window_end, 1);
      chk("win_period", run_edges, PERIOD);
   endtask

   task automatic reply(input logic [DW-1:0] v, input int d);
      for (int i = 0; i < d; i++) tick();
      cpsd_valid = 1'b1;
      cpsd       = v;
      tick();
      cpsd_valid = 1'b0;
      cpsd       = DW'($urandom);
      chk("win_end_pulse", window_end, 0);
      chk("rv_early", result_valid, 0);
      tick();
      model_decide(v);
      run_edges = 0;
      chk("rv_pulse", result_valid, 1);
      chk("class_out", {normal, af, vf}, m_cls);
   endtask

   task automatic timeout_window();
      for (int i = 0; i < int'(TIMEOUT); i++) tick();
      m_terr = 1'b1;
      run_edges = 0;
      chk("timeout_err", timeout_err, 1);
      chk("timeout_rv", result_valid, 0);
      chk("timeout_cls", {normal, af, vf}, m_cls);
   endtask

   function automatic logic [DW-1:0] rand_cpsd();
      case ($urandom % 6)
         0: return m_thr1 - DW'(1);
         1: return m_thr1;
         2: return m_thr2 - DW'(1);
         3: return m_thr2;
         4: return DW'($urandom_range(0, 50));
         default: return 16'hFFFF;
      endcase
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit            exp_err;
      bit            with_start;
      logic [DW-1:0] t1;
      logic [DW-1:0] t2;
      int            seen_we;

      rstn = 1'b0; en = 1'b1; start = 1'b0; stop = 1'b0;
      cpsd_valid = 1'b0; cpsd = '0; cfg_we = 1'b0; cfg_thr1 = '0; cfg_thr2 = '0;
      model_reset();
      tick(); tick();
      rstn = 1'b1;

      // 1: idle after reset, no window activity.
      chk("rst_cls", {normal, af, vf}, m_cls);
      chk("rst_busy", busy, 0);
      chk("rst_terr", timeout_err, 0);
      chk("rst_rv", result_valid, 0);
      seen_we = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (window_end) seen_we++;
      end
      chk("idle_no_win", seen_we, 0);

      // 5a: rejected threshold write in IDLE.
      cfg_we = 1'b1; cfg_thr1 = 16'd20; cfg_thr2 = 16'd8;
      tick();
      cfg_we = 1'b0;
      exp_err = model_cfg(16'd20, 16'd8);
      chk("cfg_err_pulse", cfg_err, exp_err);
      tick();
      chk("cfg_err_drop", cfg_err, 0);

      // 2: three normal windows give normal after warm-up.
      start_session();
      wait_window_end(); reply(16'd2, 0);
      wait_window_end(); reply(16'd3, 1);
      // 5b: write while running is ignored.
      cfg_we = 1'b1; cfg_thr1 = 16'd3; cfg_thr2 = 16'd30;
      tick();
      cfg_we = 1'b0;
      chk("cfg_run_noerr", cfg_err, 0);
      wait_window_end(); reply(16'd4, 2);
      chk("normal_set", {normal, af, vf}, 3'b100);

      // 6: VF fast path, then no-majority holds, then AF majority.
      wait_window_end(); reply(16'd12, 0);
      wait_window_end(); reply(16'd7, 1);
      chk("hold_no_major", {normal, af, vf}, 3'b001);
      wait_window_end(); reply(16'd6, 0);
      wait_window_end(); reply(16'd2, 0);
      // stop alongside cpsd_valid: abort, no update.
      wait_window_end();
      cpsd_valid = 1'b1; cpsd = 16'd15; stop = 1'b1;
      tick();
      cpsd_valid = 1'b0; stop = 1'b0;
      chk("stop_busy", busy, 0);
      chk("stop_rv", result_valid, 0);
      tick();
      chk("stop_rv2", result_valid, 0);
      chk("stop_cls", {normal, af, vf}, m_cls);

      // 3: fresh start, VF on first window despite warm-up; en freeze checks.
      start_session();
      tick(); tick();
      en = 1'b0;
      tick(); tick(); tick();
      chk("en_freeze_we", window_end, 0);
      chk("en_freeze_busy", busy, 1);
      en = 1'b1;
      wait_window_end();
      en = 1'b0;
      tick();
      chk("en_pulse_drop", window_end, 0);
      en = 1'b1;
      reply(16'd15, 0);
      chk("vf_fast", {normal, af, vf}, 3'b001);

      // 4: timeout discards the window; fill count unaffected.
      wait_window_end();
      timeout_window();
      wait_window_end(); reply(16'd2, 3);
      chk("fill_kept_hold", {normal, af, vf}, 3'b001);
      wait_window_end(); reply(16'd3, 0);
      chk("fill_full_vote", {normal, af, vf}, m_cls);
      stop = 1'b1; tick(); stop = 1'b0;
      chk("terr_sticky", timeout_err, 1);

      // Randomized sessions.
      for (int s = 0; s < 6; s++) begin
         t1 = DW'($urandom_range(0, 40));
         t2 = DW'($urandom_range(0, 40));
         with_start = 1'($urandom % 2);
         cfg_we = 1'b1; cfg_thr1 = t1; cfg_thr2 = t2; start = with_start;
         tick();
         cfg_we = 1'b0; start = 1'b0;
         exp_err = model_cfg(t1, t2);
         chk("rand_cfg_err", cfg_err, exp_err);
         if (with_start) begin
            model_start();
            run_edges = 0;
            chk("rand_start_busy", busy, 1);
            chk("rand_start_terr", timeout_err, 0);
         end else begin
            start_session();
         end
         for (int w = 0; w < 10; w++) begin
            wait_window_end();
            if ($urandom % 8 == 0) timeout_window();
            else reply(rand_cpsd(), int'($urandom % TIMEOUT));
         end
         stop = 1'b1; tick(); stop = 1'b0;
         chk("rand_stop_busy", busy, 0);
         chk("rand_stop_cls", {normal, af, vf}, m_cls);
      end

      // Reset mid-window returns everything to reset values.
      start_session();
      tick(); tick(); tick();
      rstn = 1'b0;
      #1;
      model_reset();
      chk("mid_rst_cls", {normal, af, vf}, m_cls);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_terr", timeout_err, 0);
      chk("mid_rst_we", window_end, 0);
      tick();
      rstn = 1'b1;
      start_session();
      wait_window_end(); reply(16'd12, 0);
      chk("rst_thr_vf", {normal, af, vf}, 3'b001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
